// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8:1 sample mux of the sine generator.
// Source k owns mux input k+1; sel carries the binary index k of the current owner.
// Optional grant watchdog: define ARB_TIMEOUT_EN to revoke grants that are not
// accepted within TIMEOUT_CYCLES cycles (timeout tied low otherwise).
module mux8_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] done,
  output logic       timeout
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [2:0] rr_ptr_q;
  logic [7:0] grant_q;
  logic [2:0] sel_q;
  logic       out_valid_q;
  logic [7:0] done_q;
  logic       timeout_q;
  // One-hot of the source released last cycle; it may not win in the cycle after release.
  logic [7:0] mask_q;

  logic       idle_found;
  logic [2:0] idle_idx;
  logic       next_found;
  logic [2:0] next_idx;
  logic       to_hit;
  logic       release_now;

  // First set bit of r searching upward from p with wrap; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    // Walk from the farthest offset down so the nearest candidate is written last.
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign to_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // Candidate winners: from IDLE (minus the just-released source) and for a back-to-back handoff.
  always_comb begin
    {idle_found, idle_idx} = rr_pick(req & ~mask_q, rr_ptr_q);
    {next_found, next_idx} = rr_pick(req & ~grant_q, sel_q + 3'd1);
    release_now = out_ready | ~req[sel_q] | to_hit;
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 3'd0;
      grant_q     <= 8'd0;
      sel_q       <= 3'd0;
      out_valid_q <= 1'b0;
      done_q      <= 8'd0;
      timeout_q   <= 1'b0;
      mask_q      <= 8'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      done_q    <= 8'd0;
      timeout_q <= 1'b0;
      mask_q    <= 8'd0;
      unique case (state_q)
        StIdle: begin
          if (idle_found) begin
            state_q     <= StGrant;
            grant_q     <= 8'b1 << idle_idx;
            sel_q       <= idle_idx;
            out_valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
          end
        end
        StGrant: begin
          // Accept beats withdrawal, which beats the watchdog.
          if (out_ready) begin
            done_q <= grant_q;
          end else if (req[sel_q]) begin
            timeout_q <= to_hit;
          end
          if (release_now) begin
            rr_ptr_q <= sel_q + 3'd1;
            mask_q   <= grant_q;
            if (next_found) begin
              grant_q <= 8'b1 << next_idx;
              sel_q   <= next_idx;
`ifdef ARB_TIMEOUT_EN
              cnt_q   <= 8'd0;
`endif
            end else begin
              state_q     <= StIdle;
              grant_q     <= 8'd0;
              sel_q       <= 3'd0;
              out_valid_q <= 1'b0;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] done;
  logic       timeout;

  mux8_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Model state: owner index (-1 = nobody), pointer, source barred for one cycle, wait count.
  int         m_owner;
  int         m_ptr;
  int         m_block;
  int         m_cnt;
  logic [7:0] m_done;
  logic       m_to;

  int n_cmp;
  int n_fail;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int i = 0; i < 8; i++) begin
      if (r[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_block = -1;
    m_cnt   = 0;
    m_done  = 8'd0;
    m_to    = 1'b0;
  endtask

  // Advance the model across one rising edge given the inputs seen before it.
  task automatic model_step(input logic [7:0] r, input logic rdy);
    logic [7:0] elig;
    int         k;
    bit         rel;
    m_done = 8'd0;
    m_to   = 1'b0;
    if (m_owner < 0) begin
      elig = r;
      if (m_block >= 0) elig[m_block] = 1'b0;
      m_block = -1;
      m_owner = pick(elig, m_ptr);
      m_cnt   = 0;
    end else begin
      k   = m_owner;
      rel = 1'b0;
      if (rdy) begin
        m_done[k] = 1'b1;
        rel = 1'b1;
      end else if (!r[k]) begin
        rel = 1'b1;
      end else if (ToEn && m_cnt == TO - 1) begin
        m_to = 1'b1;
        rel  = 1'b1;
      end else begin
        m_cnt++;
      end
      m_block = -1;
      if (rel) begin
        m_ptr   = (k + 1) % 8;
        m_block = k;
        elig    = r;
        elig[k] = 1'b0;
        m_owner = pick(elig, m_ptr);
        m_cnt   = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eg;
    eg = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".sel"}, 32'(sel), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".valid"}, 32'(out_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    model_step(r, rdy);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [7:0] rq;
  logic       rd;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst       = 1'b1;
    req       = 8'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while source 2 holds the mux.
    cycle("rst_pre", 8'h04, 1'b0);
    check("rst_pre_sel", 32'(sel), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_regrant", 8'h04, 1'b0);
    check("rst_regrant_grant", 32'(grant), 32'h04);
    cycle("rst_acc", 8'h04, 1'b1);
    cycle("rst_idle", 8'h00, 1'b0);

    // Single request with ready high.
    cycle("single_g", 8'h20, 1'b1);
    check("single_sel", 32'(sel), 32'd5);
    cycle("single_d", 8'h20, 1'b1);
    check("single_done", 32'(done), 32'h20);
    cycle("single_idle", 8'h00, 1'b0);
    cycle("single_idle2", 8'h00, 1'b0);

    // All sources requesting: back-to-back laps around the ring.
    for (int i = 0; i < 18; i++) cycle("wrap", 8'hFF, 1'b1);
    cycle("wrap_end", 8'h00, 1'b0);
    cycle("wrap_end2", 8'h00, 1'b0);

    // Backpressure on two requesters.
    for (int i = 0; i < 6; i++) cycle("bp_hold", 8'h81, 1'b0);
    cycle("bp_acc", 8'h81, 1'b1);
    cycle("bp_next", 8'h80, 1'b1);
    cycle("bp_idle", 8'h00, 1'b0);
    cycle("bp_idle2", 8'h00, 1'b0);

    // Withdrawal of source 3 with source 6 pending.
    cycle("wd_g", 8'h08, 1'b0);
    check("wd_sel3", 32'(sel), 32'd3);
    cycle("wd_hold", 8'h48, 1'b0);
    cycle("wd_drop", 8'h40, 1'b0);
    check("wd_sel6", 32'(sel), 32'd6);
    check("wd_nodone", 32'(done), 32'h00);
    cycle("wd_acc", 8'h40, 1'b1);
    cycle("wd_idle", 8'h00, 1'b0);

    // Lone requester stalled long enough to exercise the watchdog when it is built in.
    for (int i = 0; i < 12; i++) cycle("stall", 8'h02, 1'b0);
    cycle("stall_end", 8'h00, 1'b0);

    // Random traffic: sticky requests with occasional flips, bursty ready.
    rq = 8'd0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      rd = ($urandom_range(0, 2) == 0);
      cycle("rand", rq, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 8:1 16-bit sample mux of the sine wave generator among 8 sample sources.
- Drives the mux select, presents one valid/ready stream to the downstream consumer (DAC/output stage) and returns a completion pulse to the winning source.
- Pure control: no sample data passes through this block. Source k drives mux data input k+1 (i1..i8 map to k = 0..7).

Parameters:
- TIMEOUT_CYCLES, 16, cycles a grant may wait for out_ready before revocation (used only with ARB_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  8  per-source request; bit k high = sample on mux input k+1 valid
- grant  output  8  one-hot grant; all-zero when idle
- sel  output  3  mux select; binary index of granted source
- out_valid  output  1  muxed sample valid toward consumer
- out_ready  input  1  consumer accepts sample when out_valid && out_ready
- done  output  8  one-cycle pulse on bit k when source k's sample is accepted
- timeout  output  1  one-cycle pulse on grant revocation by watchdog (tied 0 without macro)

Behaviour:
- Reset (asynchronous, any cycle, including mid-grant): grant=0, sel=0, out_valid=0, done=0, timeout=0, state=IDLE, rr_ptr=0. Deassertion takes effect at the next rising edge.
- States:
  - IDLE: no grant outstanding.
  - GRANT: one source owns the mux.
- IDLE -> GRANT: when req != 0, registered at the next edge. Winner is the first set bit searching upward from rr_ptr, wrapping 7 -> 0. Latency is 1 cycle from req to grant/out_valid.
- In GRANT:
  - grant is one-hot, sel = index of the grant bit, and out_valid = 1.
  - sel and grant are stable for the whole GRANT period.
- Accept (out_valid && out_ready):
  - done[k] pulses in the following cycle.
  - rr_ptr <= k+1 (mod 8).
  - If any other req is pending (excluding bit k), the next winner is granted in the following cycle with no idle gap; otherwise the block returns to IDLE.
  - req[k] is ignored in the cycle after accept, so a source that has not yet dropped req is not regranted early.
- Withdrawal: if req[k] of the granted source falls before accept, the grant is revoked at the next edge. No done pulse is issued, rr_ptr <= k+1, and arbitration follows the same rules as accept.
- Simultaneous accept and withdrawal in the same cycle: accept wins and done pulses.
- Requests from other sources during GRANT are queued implicitly; they are not preempted.
- Fairness: every continuously requesting source is granted within 8 grants.
- done and timeout are never asserted together.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on each grant and increments each GRANT cycle without accept.
  - When the count reaches TIMEOUT_CYCLES-1 without accept, the grant is revoked at the next edge and timeout pulses for 1 cycle.
  - rr_ptr <= k+1 and the next pending source is granted as for withdrawal. No done pulse is issued.
- Undefined: no counter; a grant is held indefinitely until accept or withdrawal; timeout is tied 0.

Test Plan:
- Reset mid-grant: req=8'h04, grant issued, assert rst async between edges -> grant=0, sel=0, out_valid=0 immediately; after release, re-grant source 2 one cycle later.
- Single request: req=8'h20, out_ready=1 -> cycle+1 grant=8'h20, sel=5, out_valid=1; cycle+2 done=8'h20; return to IDLE when req drops.
- Round-robin wrap: req=8'hFF held, out_ready=1 -> sel sequence 0,1,2,...,7,0 back-to-back; each done bit pulses once per lap.
- Backpressure: req=8'h81, out_ready=0 for 5 cycles -> sel=0 held stable, out_valid=1 throughout; on out_ready=1 done=8'h01, next cycle sel=7.
- Withdrawal: grant on source 3, drop req[3] before out_ready -> grant=0 next edge, no done; pending req[6] granted with sel=6.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: req=8'h02, out_ready=0 -> timeout pulse after 4 grant cycles, grant revoked; source 1 regranted if still requesting and no other requester is pending.
